adbg_jsp_apb_biu_fifo: RTL

//  Parametrised single-clock JTAG Serial Port bus interface: two FIFOs (debugger->CPU RX, CPU->debugger TX)

---
 rtl/adbg_jsp_pkg.sv | 41 ++++
 rtl/adbg_jsp_sync_fifo.sv | 60 ++++++
 rtl/adbg_jsp_apb_biu_fifo.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/adbg_jsp_pkg.sv
// Shared constants for the JSP APB bus interface: register indices, IIR codes,
// LSR/FCR bit positions and the RX trigger-level decode.
package adbg_jsp_pkg;

    localparam logic [2:0] IDX_RBR_THR = 3'd0;
    localparam logic [2:0] IDX_IER     = 3'd1;
    localparam logic [2:0] IDX_IIR_FCR = 3'd2;
    localparam logic [2:0] IDX_LCR     = 3'd3;
    localparam logic [2:0] IDX_LSR     = 3'd5;
    localparam logic [2:0] IDX_SCR     = 3'd7;

    localparam logic [7:0] IIR_NONE = 8'h01;
    localparam logic [7:0] IIR_THRE = 8'h02;
    localparam logic [7:0] IIR_RDA  = 8'h04;
    localparam logic [7:0] IIR_RLS  = 8'h06;
    localparam logic [7:0] IIR_CTI  = 8'h0C;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    localparam int FCR_CLR_RX = 1;
    localparam int FCR_CLR_TX = 2;

    localparam logic [1:0] TRIG_ONE     = 2'b00;
    localparam logic [1:0] TRIG_QUARTER = 2'b01;
    localparam logic [1:0] TRIG_HALF    = 2'b10;
    localparam logic [1:0] TRIG_NEARLY  = 2'b11;

    // RX occupancy at which the data-available interrupt fires.
    function automatic int trig_level(input logic [1:0] sel, input int depth);
        case (sel)
            TRIG_ONE:     return 1;
            TRIG_QUARTER: return depth / 4;
            TRIG_HALF:    return depth / 2;
            default:      return depth - 2;
        endcase
    endfunction

endpackage

// File: rtl/adbg_jsp_sync_fifo.sv
// First-word-fall-through synchronous FIFO with clear. Head reads as 0 when
// empty. A push on full is accepted only if a pop happens in the same cycle.
module adbg_jsp_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       push_acc_o,
    output logic                       pop_acc_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    // A clear in the same cycle swallows any push or pop.
    assign push_acc_o = push_ok & ~clr_i;
    assign pop_acc_o  = pop_ok & ~clr_i;
    assign count_o    = count_q;
    assign data_o     = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates the head.
    always_ff @(posedge clk_i) begin
        if (push_acc_o && !rst_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/adbg_jsp_apb_biu_fifo.sv
// JTAG serial port APB interface: RX/TX FIFOs behind a 16550-subset register
// file with trigger level, RX timeout and prioritised interrupt.
module adbg_jsp_apb_biu_fifo
    import adbg_jsp_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 256,
    localparam int CNT_W  = $clog2(DEPTH+1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        dbg_data_i,
    input  logic              dbg_wr_strobe_i,
    input  logic              dbg_rd_strobe_i,
    output logic [7:0]        dbg_data_o,
    output logic [CNT_W-1:0]  dbg_bytes_available_o,
    output logic [CNT_W-1:0]  dbg_bytes_free_o,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [7:0]        PWDATA,
    output logic [7:0]        PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              int_o
);
    localparam int TMO_W = $clog2(TIMEOUT+1);

    logic [2:0]       idx;
    logic             access, wr_acc, rd_acc;
    logic             rx_clr, tx_clr, rx_pop, tx_push;
    logic [7:0]       rx_data;
    logic [CNT_W-1:0] rx_count, tx_count, trig_lvl;
    logic             rx_empty, rx_full, rx_push_acc, rx_pop_acc;
    logic             tx_empty, tx_full, tx_push_acc, tx_pop_acc;
    logic             tx_going_empty, timeout_evt, iir_thre_rd;
    logic [7:0]       lsr, iir, rd_mux;
    logic [3:0]       ier_q;
    logic [1:0]       trig_sel_q;
    logic [7:0]       lcr_q, scr_q;
    logic             oe_q, thre_pend_q, int_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             unused_bits;

    assign idx     = PADDR[4:2];
    assign access  = PSEL & PENABLE;
    assign wr_acc  = access & PWRITE;
    assign rd_acc  = access & ~PWRITE;
    assign rx_clr  = wr_acc & (idx == IDX_IIR_FCR) & PWDATA[FCR_CLR_RX];
    assign tx_clr  = wr_acc & (idx == IDX_IIR_FCR) & PWDATA[FCR_CLR_TX];
    assign rx_pop  = rd_acc & (idx == IDX_RBR_THR);
    assign tx_push = wr_acc & (idx == IDX_RBR_THR);
    assign unused_bits = ^{PADDR, tx_full};

    adbg_jsp_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(rx_clr),
        .push_i(dbg_wr_strobe_i), .data_i(dbg_data_i), .pop_i(rx_pop),
        .data_o(rx_data), .count_o(rx_count), .empty_o(rx_empty), .full_o(rx_full),
        .push_acc_o(rx_push_acc), .pop_acc_o(rx_pop_acc)
    );

    adbg_jsp_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(tx_clr),
        .push_i(tx_push), .data_i(PWDATA), .pop_i(dbg_rd_strobe_i),
        .data_o(dbg_data_o), .count_o(tx_count), .empty_o(tx_empty), .full_o(tx_full),
        .push_acc_o(tx_push_acc), .pop_acc_o(tx_pop_acc)
    );

    assign dbg_bytes_available_o = tx_count;
    assign dbg_bytes_free_o      = CNT_W'(DEPTH) - rx_count;
    assign trig_lvl              = CNT_W'(trig_level(trig_sel_q, DEPTH));

    assign tx_going_empty = ~tx_empty &
                            (tx_clr | (tx_pop_acc & ~tx_push_acc & (tx_count == CNT_W'(1))));
    assign timeout_evt    = (tmo_cnt_q == TMO_W'(TIMEOUT)) & ~rx_empty & (rx_count < trig_lvl);

    always_comb begin
        lsr = '0;
        lsr[LSR_DR]   = ~rx_empty;
        lsr[LSR_OE]   = oe_q;
        lsr[LSR_THRE] = tx_empty;
        lsr[LSR_TEMT] = tx_empty;
    end

    // Interrupt cause priority encoder.
    always_comb begin
        iir = IIR_NONE;
        if (oe_q && ier_q[2])                             iir = IIR_RLS;
        else if ((rx_count >= trig_lvl) && ier_q[0])      iir = IIR_RDA;
        else if (timeout_evt && ier_q[0])                 iir = IIR_CTI;
        else if (thre_pend_q && ier_q[1])                 iir = IIR_THRE;
    end

    assign iir_thre_rd = rd_acc & (idx == IDX_IIR_FCR) & (iir == IIR_THRE);

    // Read data mux; unmapped indices read as zero.
    always_comb begin
        rd_mux = '0;
        case (idx)
            IDX_RBR_THR: rd_mux = rx_data;
            IDX_IER:     rd_mux = {4'b0, ier_q};
            IDX_IIR_FCR: rd_mux = iir;
            IDX_LCR:     rd_mux = lcr_q;
            IDX_LSR:     rd_mux = lsr;
            IDX_SCR:     rd_mux = scr_q;
            default:     rd_mux = '0;
        endcase
    end

    assign PRDATA  = PSEL ? rd_mux : 8'h00;
    assign PREADY  = 1'b1;
    assign PSLVERR = access & ((idx == 3'd4) | (idx == 3'd6));
    assign int_o   = int_q;

    // Software-visible configuration registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ier_q      <= '0;
            trig_sel_q <= TRIG_ONE;
            lcr_q      <= 8'h03;
            scr_q      <= '0;
        end else if (wr_acc) begin
            case (idx)
                IDX_IER:     ier_q      <= PWDATA[3:0];
                IDX_IIR_FCR: trig_sel_q <= PWDATA[7:6];
                IDX_LCR:     lcr_q      <= PWDATA;
                IDX_SCR:     scr_q      <= PWDATA;
                default:     ;
            endcase
        end
    end

    // Sticky overrun: a new overrun in the same cycle as an LSR read wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) oe_q <= 1'b0;
        else if (dbg_wr_strobe_i && rx_full && !rx_pop_acc && !rx_clr) oe_q <= 1'b1;
        else if (rd_acc && idx == IDX_LSR) oe_q <= 1'b0;
    end

    // THR-empty pending: armed on TX draining, cleared by THR write or IIR read of it.
    always_ff @(posedge clk_i) begin
        if (rst_i) thre_pend_q <= 1'b0;
        else if (tx_going_empty) thre_pend_q <= 1'b1;
        else if (tx_push || iir_thre_rd) thre_pend_q <= 1'b0;
    end

    // RX idle counter, restarted by any RX activity or an empty RX FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) tmo_cnt_q <= '0;
        else if (rx_push_acc || rx_pop_acc || rx_empty) tmo_cnt_q <= '0;
        else if (tmo_cnt_q != TMO_W'(TIMEOUT)) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end

    // Registered interrupt line.
    always_ff @(posedge clk_i) begin
        if (rst_i) int_q <= 1'b0;
        else       int_q <= (iir != IIR_NONE);
    end

endmodule
